mem_bus_ctrl: RTL and testbench

Memory/peripheral bus controller that sits directly downstream of the CPU core's external bus. It consumes the core's multiplexed address/data bus (`Data_out` with `ALE`) and its `nME`, `RnW` and `ENB` strobes. It decodes each access to a synchronous RAM port or to a request/acknowledge peripheral port, and stalls the core through `nWait` until the access completes. Read data is returned to the core on a registered `Data_in`.

---
 rtl/mem_bus_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: decodes core bus accesses onto a synchronous RAM port or a
// request/acknowledge peripheral port, stalling the core via nWait until done.
module mem_bus_ctrl #(
    parameter int unsigned RAM_WAIT    = 1,
    parameter int unsigned PER_TIMEOUT = 255,
    parameter logic [3:0]  PER_NIBBLE  = 4'hF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Data_out,
    input  logic        ALE,
    input  logic        nME,
    input  logic        RnW,
    input  logic        ENB,
    output logic [15:0] Data_in,
    output logic        nWait,
    output logic [14:0] RamAddr,
    output logic        RamEn,
    output logic        RamWe,
    output logic [15:0] RamWdata,
    input  logic [15:0] RamRdata,
    output logic [11:0] PerAddr,
    output logic        PerReq,
    output logic        PerWe,
    output logic [15:0] PerWdata,
    input  logic [15:0] PerRdata,
    input  logic        PerAck,
    output logic        BusErr
);

    localparam logic [7:0] RAM_WAIT_C    = 8'(RAM_WAIT);
    localparam logic [7:0] PER_TIMEOUT_C = 8'(PER_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RAM_WAIT,
        S_PER_REQ,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        buserr_q, buserr_d;

    // State, latched access fields, read data and sticky error flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rnw_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rnw_q    <= rnw_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            buserr_q <= buserr_d;
        end
    end

    // Next-state logic; a core abort (nME high) takes priority over completion.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rnw_d    = rnw_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        buserr_d = buserr_q;
        unique case (state_q)
            S_IDLE: begin
                if (ALE) begin
                    addr_d  = Data_out;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!nME) begin
                    rnw_d   = RnW;
                    wdata_d = Data_out;
                    if (addr_q[15:12] == PER_NIBBLE) begin
                        cnt_d   = PER_TIMEOUT_C;
                        state_d = S_PER_REQ;
                    end else begin
                        cnt_d   = RAM_WAIT_C;
                        state_d = S_RAM_WAIT;
                    end
                end
            end
            S_RAM_WAIT: begin
                if (nME) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (rnw_q) rdata_d = RamRdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PER_REQ: begin
                if (nME) begin
                    state_d = S_IDLE;
                end else if (PerAck) begin
                    if (rnw_q) rdata_d = PerRdata;
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    buserr_d = 1'b1;
                    if (rnw_q) rdata_d = 16'hDEAD;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                if (nME) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus-side strobes are decoded straight from the state register.
    always_comb begin
        RamEn    = (state_q == S_RAM_WAIT);
        RamWe    = RamEn && !rnw_q;
        PerReq   = (state_q == S_PER_REQ);
        PerWe    = PerReq && !rnw_q;
        nWait    = !(RamEn || PerReq);
        RamAddr  = addr_q[14:0];
        PerAddr  = addr_q[11:0];
        RamWdata = wdata_q;
        PerWdata = wdata_q;
        Data_in  = rdata_q;
        BusErr   = buserr_q;
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (RAM_WAIT=1, PER_TIMEOUT=4).
module tb_mem_bus_ctrl;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] Data_out;
    logic        ALE, nME, RnW, ENB;
    logic [15:0] Data_in;
    logic        nWait;
    logic [14:0] RamAddr;
    logic        RamEn, RamWe;
    logic [15:0] RamWdata, RamRdata;
    logic [11:0] PerAddr;
    logic        PerReq, PerWe;
    logic [15:0] PerWdata, PerRdata;
    logic        PerAck;
    logic        BusErr;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mem_bus_ctrl #(.RAM_WAIT(1), .PER_TIMEOUT(4), .PER_NIBBLE(4'hF)) dut (
        .Clock(Clock), .Reset(Reset), .Data_out(Data_out), .ALE(ALE),
        .nME(nME), .RnW(RnW), .ENB(ENB), .Data_in(Data_in), .nWait(nWait),
        .RamAddr(RamAddr), .RamEn(RamEn), .RamWe(RamWe), .RamWdata(RamWdata),
        .RamRdata(RamRdata), .PerAddr(PerAddr), .PerReq(PerReq), .PerWe(PerWe),
        .PerWdata(PerWdata), .PerRdata(PerRdata), .PerAck(PerAck), .BusErr(BusErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rnw;
        int          ack_dly;   // -1: peripheral never acknowledges
        logic [15:0] rdata;
        logic        is_per;
        int          exp_wait;
        logic [15:0] exp_din;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_access(input vec_t v);
        int waits;
        int ram_cyc;
        int per_cyc;
        ALE = 1'b1; Data_out = v.addr;
        tick();
        ALE = 1'b0; nME = 1'b0; RnW = v.rnw; ENB = !v.rnw; Data_out = v.wdata;
        RamRdata = v.rdata; PerRdata = v.rdata;
        tick();
        if (v.is_per) begin
            chk("per_addr", 32'(PerAddr), 32'(v.addr[11:0]));
            chk("per_we", 32'(PerWe), 32'(!v.rnw));
            if (!v.rnw) chk("per_wdata", 32'(PerWdata), 32'(v.wdata));
        end else begin
            chk("ram_addr", 32'(RamAddr), 32'(v.addr[14:0]));
            chk("ram_we", 32'(RamWe), 32'(!v.rnw));
            if (!v.rnw) chk("ram_wdata", 32'(RamWdata), 32'(v.wdata));
        end
        waits = 0; ram_cyc = 0; per_cyc = 0;
        while (nWait == 1'b0 && waits < 300) begin
            if (RamEn) ram_cyc++;
            if (PerReq) per_cyc++;
            PerAck = (waits == v.ack_dly);
            tick();
            waits++;
        end
        PerAck = 1'b0;
        chk("stall_cycles", 32'(waits), 32'(v.exp_wait));
        chk("ram_en_cycles", 32'(ram_cyc), v.is_per ? 32'd0 : 32'(v.exp_wait));
        chk("per_req_cycles", 32'(per_cyc), v.is_per ? 32'(v.exp_wait) : 32'd0);
        chk("data_in", 32'(Data_in), 32'(v.exp_din));
        chk("bus_err", 32'(BusErr), 32'(v.exp_err));
        nME = 1'b1; ENB = 1'b0;
        tick();
        chk("idle_nwait", 32'(nWait), 32'd1);
    endtask

    initial begin
        //          addr      wdata     rnw  ack rdata     per  wait din       err
        vecs[0] = '{16'h0123, 16'h0000, 1'b1, -1, 16'hBEEF, 1'b0, 2, 16'hBEEF, 1'b0};
        vecs[1] = '{16'h7FFE, 16'h5A5A, 1'b0, -1, 16'h1357, 1'b0, 2, 16'hBEEF, 1'b0};
        vecs[2] = '{16'hF010, 16'h0000, 1'b1,  3, 16'h00C3, 1'b1, 4, 16'h00C3, 1'b0};
        vecs[3] = '{16'hF020, 16'h1234, 1'b0,  0, 16'h2222, 1'b1, 1, 16'h00C3, 1'b0};
        vecs[4] = '{16'hF0FF, 16'h0000, 1'b1,  4, 16'h0777, 1'b1, 5, 16'h0777, 1'b0};
        vecs[5] = '{16'hF004, 16'h0000, 1'b1, -1, 16'h4444, 1'b1, 5, 16'hDEAD, 1'b1};
        vecs[6] = '{16'h8001, 16'h0000, 1'b1, -1, 16'h1111, 1'b0, 2, 16'h1111, 1'b1};

        Reset = 1'b1; Data_out = '0; ALE = 1'b0; nME = 1'b1; RnW = 1'b1; ENB = 1'b0;
        RamRdata = '0; PerRdata = '0; PerAck = 1'b0;
        tick(); tick();
        chk("rst_data_in", 32'(Data_in), 32'd0);
        chk("rst_nwait", 32'(nWait), 32'd1);
        chk("rst_buserr", 32'(BusErr), 32'd0);
        chk("rst_strobes", 32'({RamEn, RamWe, PerReq, PerWe}), 32'd0);
        chk("rst_addrs", 32'({RamAddr, PerAddr}), 32'd0);
        chk("rst_wdata", 32'({RamWdata, PerWdata}), 32'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) do_access(vecs[i]);

        // Core abort in the second RAM wait cycle: back to idle, Data_in kept.
        ALE = 1'b1; Data_out = 16'h0200;
        tick();
        ALE = 1'b0; nME = 1'b0; RnW = 1'b1; RamRdata = 16'h9999;
        tick();
        tick();
        chk("abort_pre_ramen", 32'(RamEn), 32'd1);
        chk("abort_pre_nwait", 32'(nWait), 32'd0);
        nME = 1'b1;
        tick();
        chk("abort_ramen", 32'(RamEn), 32'd0);
        chk("abort_nwait", 32'(nWait), 32'd1);
        chk("abort_data_in", 32'(Data_in), 32'h1111);
        tick();
        chk("abort_idle", 32'({RamEn, PerReq, nWait}), 32'b001);

        // Reset while a peripheral request is pending.
        ALE = 1'b1; Data_out = 16'hF030;
        tick();
        ALE = 1'b0; nME = 1'b0; RnW = 1'b1;
        tick();
        tick();
        chk("rst_pend_perreq", 32'(PerReq), 32'd1);
        Reset = 1'b1;
        tick();
        chk("rstp_perreq", 32'(PerReq), 32'd0);
        chk("rstp_nwait", 32'(nWait), 32'd1);
        chk("rstp_data_in", 32'(Data_in), 32'd0);
        chk("rstp_buserr", 32'(BusErr), 32'd0);
        Reset = 1'b0; nME = 1'b1;
        tick();
        do_access('{16'h0042, 16'h0000, 1'b1, -1, 16'hABCD, 1'b0, 2, 16'hABCD, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
